dsp_mac_sequencer: RTL

- Controller that sequences one dsp_t1_20x18x64 multiply-accumulate slice through length-N dot products.
- Accepts a job (length plus arithmetic config), then streams (a,b) operand pairs into the DSP over a valid/ready handshake.
- Drives load_acc and the output-stage controls, waits out the DSP pipeline, and returns the 38-bit result over a valid/ready handshake.
- Sits between a sample/coefficient source and a single DSP instance.

---
 rtl/dsp_mac_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/dsp_mac_sequencer.sv
// Sequences one dsp_t1_20x18x64 MAC slice through length-N dot products and returns the 38-bit sum.
// Optional stall counter output enabled by defining DSP_MAC_SEQUENCER_PERF_EN.
module dsp_mac_sequencer #(
  parameter int DSP_LATENCY = 1,
  parameter int LEN_W       = 8
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [5:0]       cfg_shift_i,
  input  logic             cfg_round_i,
  input  logic             cfg_sat_i,
  input  logic             cfg_sub_i,
  input  logic             cfg_unsigned_a_i,
  input  logic             cfg_unsigned_b_i,
  output logic             busy_o,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [19:0]      s_a_i,
  input  logic [17:0]      s_b_i,
  output logic [19:0]      a_o,
  output logic [17:0]      b_o,
  output logic [2:0]       feedback_o,
  output logic             load_acc_o,
  output logic             unsigned_a_o,
  output logic             unsigned_b_o,
  output logic [5:0]       shift_right_o,
  output logic             round_o,
  output logic             saturate_enable_o,
  output logic             subtract_o,
  input  logic [37:0]      dsp_z_i,
  output logic             r_valid_o,
  input  logic             r_ready_i,
`ifdef DSP_MAC_SEQUENCER_PERF_EN
  output logic [15:0]      stall_cnt_o,
`endif
  output logic [37:0]      r_data_o
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, RESULT} state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] rem;
  logic             first_term;
  logic [1:0]       drain_cnt;
  logic             accept, s_fire, drain_done;

  assign feedback_o = 3'b000;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    busy_o     = 1'b1;
    s_ready_o  = 1'b0;
    r_valid_o  = 1'b0;
    accept     = 1'b0;
    s_fire     = 1'b0;
    drain_done = 1'b0;
    case (state)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i && (len_i != '0)) begin
          accept    = 1'b1;
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        s_ready_o = 1'b1;
        s_fire    = s_valid_i;
        if (s_valid_i && (rem == LEN_W'(1))) state_nxt = DRAIN;
      end
      DRAIN: begin
        // The last term reaches dsp_z_i DSP_LATENCY cycles after it was issued.
        if (drain_cnt == 2'(DSP_LATENCY)) begin
          drain_done = 1'b1;
          state_nxt  = RESULT;
        end
      end
      RESULT: begin
        r_valid_o = 1'b1;
        if (r_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      rem               <= '0;
      first_term        <= 1'b0;
      drain_cnt         <= 2'd0;
      a_o               <= '0;
      b_o               <= '0;
      load_acc_o        <= 1'b0;
      shift_right_o     <= '0;
      round_o           <= 1'b0;
      saturate_enable_o <= 1'b0;
      subtract_o        <= 1'b0;
      unsigned_a_o      <= 1'b0;
      unsigned_b_o      <= 1'b0;
      r_data_o          <= '0;
    end else begin
      if (accept) begin
        rem               <= len_i;
        first_term        <= 1'b1;
        drain_cnt         <= 2'd0;
        shift_right_o     <= cfg_shift_i;
        round_o           <= cfg_round_i;
        saturate_enable_o <= cfg_sat_i;
        subtract_o        <= cfg_sub_i;
        unsigned_a_o      <= cfg_unsigned_a_i;
        unsigned_b_o      <= cfg_unsigned_b_i;
      end
      if (s_fire) begin
        // First term reloads the accumulator from the product; later terms add.
        a_o        <= s_a_i;
        b_o        <= s_b_i;
        load_acc_o <= ~first_term;
        first_term <= 1'b0;
        rem        <= rem - LEN_W'(1);
      end else if (state == ACCUM || state == DRAIN) begin
        // Zero operands with accumulate keep the running sum untouched.
        a_o        <= '0;
        b_o        <= '0;
        load_acc_o <= 1'b1;
      end
      if (state == DRAIN && !drain_done) drain_cnt <= drain_cnt + 2'd1;
      if (drain_done) r_data_o <= dsp_z_i;
    end
  end

`ifdef DSP_MAC_SEQUENCER_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i)                          stall_cnt_o <= '0;
    else if (accept)                      stall_cnt_o <= '0;
    else if (state == ACCUM && !s_valid_i) stall_cnt_o <= sat_inc(stall_cnt_o);
  end
`endif

endmodule
